fp16_to_fixed: RTL and testbench

- Pipelined converter from an IEEE binary16 float to a signed two's-complement fixed-point value.
- It is the inverse of the normalizer path: the LZC-driven normalizer packs integers into floats; this block shifts floats back out into integers.
- It feeds fixed-point consumers in the path tracer, such as pixel accumulators and grid/voxel index math.
- Uses a 3-stage pipeline with a valid/ready handshake at both ends.

---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp16_unpack.sv | 36 +++
 rtl/fp16_to_fixed.sv | 163 ++++++++++++++++
 tb/tb_fp16_to_fixed.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared binary16 definitions for float unpacking and float-to-fixed conversion.
package fp_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS  = 15;
    localparam int SIG_W = MAN_W + 1;
    localparam int SH_W  = 7;

    typedef enum logic [2:0] {
        ZERO,
        SUB,
        NORM,
        INF,
        NAN
    } fp_class_e;

    // sh is a two's-complement shift count: value = sig * 2^sh in output LSB units.
    typedef struct packed {
        logic            sign;
        fp_class_e       cls;
        logic [SIG_W-1:0] sig;
        logic [SH_W-1:0]  sh;
    } fp16_unpacked_t;

endpackage

// File: rtl/fp16_unpack.sv
// Combinational binary16 classifier: splits fields, restores the hidden bit and
// computes the shift that places the significand on a fixed-point grid.
module fp16_unpack
    import fp_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  logic [15:0]    data_i,
    output fp16_unpacked_t op_o
);

    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic [EXP_W-1:0] e_eff;

    always_comb begin
        op_o  = '0;
        e     = data_i[14:10];
        m     = data_i[9:0];
        e_eff = (e == '0) ? EXP_W'(1) : e;

        op_o.sign = data_i[15];
        op_o.sig  = {e != '0, m};
        // Subnormals share the exponent of e=1, so no flush-to-zero is needed.
        op_o.sh   = SH_W'(e_eff) + SH_W'(FRAC_BITS) - SH_W'(BIAS + MAN_W);

        if (e == '1) begin
            op_o.cls = (m == '0) ? INF : NAN;
        end else if (e == '0) begin
            op_o.cls = (m == '0) ? ZERO : SUB;
        end else begin
            op_o.cls = NORM;
        end
    end

endmodule

// File: rtl/fp16_to_fixed.sv
// Three-stage binary16 to signed Q(INT_BITS).(FRAC_BITS) converter with
// round-to-nearest-even and saturation; valid/ready at both ends.
module fp16_to_fixed
    import fp_pkg::*;
#(
    parameter int INT_BITS  = 16,
    parameter int FRAC_BITS = 16,
    parameter int W         = INT_BITS + FRAC_BITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_ovf,
    output logic         out_nan
);

    localparam logic [W+1:0] NEG_LIM = (W+2)'(1) << (W - 1);
    localparam logic [W+1:0] POS_LIM = NEG_LIM - (W+2)'(1);
    localparam logic [W-1:0] SAT_NEG = W'(1) << (W - 1);
    localparam logic [W-1:0] SAT_POS = ~SAT_NEG;

    logic en;

    // Stage 1: unpacked operand
    fp16_unpacked_t op_d;
    fp16_unpacked_t s1_q;
    logic           v1_q;

    // Stage 2: shifted magnitude plus rounding bits
    logic      s2_sign_d, s2_sign_q;
    fp_class_e s2_cls_d, s2_cls_q;
    logic [W:0] s2_mag_d, s2_mag_q;
    logic      s2_g_d, s2_g_q;
    logic      s2_r_d, s2_r_q;
    logic      s2_st_d, s2_st_q;
    logic      s2_povf_d, s2_povf_q;
    logic      v2_q;

    // Stage 3: output register
    logic [W-1:0] out_data_d, out_data_q;
    logic         out_ovf_d, out_ovf_q;
    logic         out_nan_d, out_nan_q;
    logic         out_valid_q;

    logic [63:0]    wide;
    logic [36:0]    rtmp;
    logic [SH_W-1:0] nsh;

    logic           inc;
    logic [W+1:0]   rmag;
    logic [W-1:0]   mag_lo;
    logic [W-1:0]   sat;
    logic           fin_ovf;

    assign en        = ~out_valid_q | out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_nan   = out_nan_q;

    fp16_unpack #(
        .FRAC_BITS(FRAC_BITS)
    ) u_unpack (
        .data_i(in_data),
        .op_o  (op_d)
    );

    always_comb begin
        wide      = '0;
        rtmp      = '0;
        nsh       = SH_W'(0) - s1_q.sh;
        s2_g_d    = 1'b0;
        s2_r_d    = 1'b0;
        s2_st_d   = 1'b0;
        s2_sign_d = s1_q.sign;
        s2_cls_d  = s1_q.cls;

        if (!s1_q.sh[SH_W-1]) begin
            wide = 64'(s1_q.sig) << s1_q.sh;
        end else begin
            // 26 zero bits below the significand keep every shifted-out bit.
            rtmp    = {s1_q.sig, 26'd0} >> nsh;
            wide    = 64'(rtmp[36:26]);
            s2_g_d  = rtmp[25];
            s2_r_d  = rtmp[24];
            s2_st_d = |rtmp[23:0];
        end

        s2_mag_d  = wide[W:0];
        s2_povf_d = |(wide >> (W + 1));
    end

    always_comb begin
        inc     = s2_g_q & (s2_r_q | s2_st_q | s2_mag_q[0]);
        rmag    = {1'b0, s2_mag_q} + (W+2)'(inc);
        mag_lo  = rmag[W-1:0];
        fin_ovf = s2_povf_q | (s2_sign_q ? (rmag > NEG_LIM) : (rmag > POS_LIM));
        sat     = s2_sign_q ? SAT_NEG : SAT_POS;

        out_data_d = '0;
        out_ovf_d  = 1'b0;
        out_nan_d  = 1'b0;

        case (s2_cls_q)
            NAN: begin
                out_nan_d = 1'b1;
            end
            INF: begin
                out_data_d = sat;
                out_ovf_d  = 1'b1;
            end
            ZERO: begin
                out_data_d = '0;
            end
            default: begin
                if (fin_ovf) begin
                    out_data_d = sat;
                    out_ovf_d  = 1'b1;
                end else begin
                    out_data_d = s2_sign_q ? ('0 - mag_lo) : mag_lo;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_nan_q   <= 1'b0;
        end else if (en) begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            out_data_q  <= v2_q ? out_data_d : '0;
            out_ovf_q   <= v2_q & out_ovf_d;
            out_nan_q   <= v2_q & out_nan_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_q      <= op_d;
            s2_sign_q <= s2_sign_d;
            s2_cls_q  <= s2_cls_d;
            s2_mag_q  <= s2_mag_d;
            s2_g_q    <= s2_g_d;
            s2_r_q    <= s2_r_d;
            s2_st_q   <= s2_st_d;
            s2_povf_q <= s2_povf_d;
        end
    end

endmodule

// File: tb/tb_fp16_to_fixed.sv
// Directed bench for fp16_to_fixed at the default Q16.16 configuration.
module tb_fp16_to_fixed;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_nan;

    int checks   = 0;
    int failures = 0;

    logic [15:0] bp_in  [6];
    logic [31:0] bp_exp [6];

    fp16_to_fixed #(
        .INT_BITS (16),
        .FRAC_BITS(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf),
        .out_nan  (out_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sends one operand into an empty pipe and checks the 3-cycle latency and result.
    task automatic convert(input logic [15:0] x, input logic [31:0] ed,
                           input logic eo, input logic enan, input string tag);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x;
        #1;
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk({tag, "_early"}, 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(out_data), 64'(ed));
        chk({tag, "_ovf"}, 64'(out_ovf), 64'(eo));
        chk({tag, "_nan"}, 64'(out_nan), 64'(enan));
    endtask

    initial begin
        int          sent;
        int          rcvd;
        logic        stalled_prev;
        logic [31:0] prev_data;
        logic        in_x;
        logic        out_x;

        bp_in[0] = 16'h3C00; bp_exp[0] = 32'h0001_0000;
        bp_in[1] = 16'h4000; bp_exp[1] = 32'h0002_0000;
        bp_in[2] = 16'hBC00; bp_exp[2] = 32'hFFFF_0000;
        bp_in[3] = 16'h3800; bp_exp[3] = 32'h0000_8000;
        bp_in[4] = 16'h0400; bp_exp[4] = 32'h0000_0004;
        bp_in[5] = 16'hC100; bp_exp[5] = 32'hFFFD_8000;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_data", 64'(out_data), 64'd0);
        chk("reset_ovf", 64'(out_ovf), 64'd0);
        chk("reset_nan", 64'(out_nan), 64'd0);
        chk("reset_rdy", 64'(in_ready), 64'd1);

        convert(16'h3C00, 32'h0001_0000, 1'b0, 1'b0, "one");
        convert(16'hC100, 32'hFFFD_8000, 1'b0, 1'b0, "neg2p5");
        convert(16'h8000, 32'h0000_0000, 1'b0, 1'b0, "negzero");
        convert(16'h0080, 32'h0000_0000, 1'b0, 1'b0, "tie_even_0");
        convert(16'h0180, 32'h0000_0002, 1'b0, 1'b0, "tie_even_2");
        convert(16'h0001, 32'h0000_0000, 1'b0, 1'b0, "tiny_sub");
        convert(16'h0400, 32'h0000_0004, 1'b0, 1'b0, "min_norm");
        convert(16'h7BFF, 32'h7FFF_FFFF, 1'b1, 1'b0, "max_fin");
        convert(16'h7C00, 32'h7FFF_FFFF, 1'b1, 1'b0, "pos_inf");
        convert(16'hFC00, 32'h8000_0000, 1'b1, 1'b0, "neg_inf");
        convert(16'hF800, 32'h8000_0000, 1'b0, 1'b0, "neg_exact");
        convert(16'h7E00, 32'h0000_0000, 1'b0, 1'b1, "nan");

        // Backpressure: out_ready low for cycles 4..8 while streaming six operands.
        sent         = 0;
        rcvd         = 0;
        stalled_prev = 1'b0;
        prev_data    = '0;
        for (int cyc = 0; cyc < 60 && rcvd < 6; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc < 9);
            if (sent < 6) begin
                in_valid = 1'b1;
                in_data  = bp_in[sent];
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
            end
            #1;
            if (stalled_prev) begin
                chk("bp_stall_valid", 64'(out_valid), 64'd1);
                chk("bp_stall_data", 64'(out_data), 64'(prev_data));
            end
            chk("bp_in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            in_x  = in_valid && in_ready;
            out_x = out_valid && out_ready;
            if (out_x) begin
                chk("bp_data", 64'(out_data), 64'(bp_exp[rcvd]));
                chk("bp_ovf", 64'(out_ovf), 64'd0);
                rcvd++;
            end
            stalled_prev = out_valid && !out_ready;
            prev_data    = out_data;
            if (in_x) sent++;
        end
        chk("bp_count", 64'(rcvd), 64'd6);
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("bp_drain", 64'(out_valid), 64'd0);
        end

        // Reset with a full, stalled pipe.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h4000;
        @(negedge clk);
        in_data   = 16'hBC00;
        @(negedge clk);
        in_data   = 16'h3800;
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = '0;
        chk("rst_full_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        chk("rst_flush_valid", 64'(out_valid), 64'd0);
        repeat (6) begin
            @(negedge clk);
            chk("rst_no_stale", 64'(out_valid), 64'd0);
        end
        convert(16'h3C00, 32'h0001_0000, 1'b0, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
